// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serialises DDS samples into 16-bit SPI frames for a
// DAC121S101-class converter (SYNC/SCLK/DIN, data sampled on falling SCLK).
// Frame word is {2'b00, pd_mode, data12}, shifted MSB first.
// Optional macro DAC_SPI_TX_SKID_EN adds a one-entry holding buffer so a
// sample can be accepted while a frame is in progress and the next frame
// can start straight from the end of the current one.
module dac_spi_tx #(
   parameter int AMP_WIDTH      = 12,
   parameter int SCLK_DIV       = 2,
   parameter int CS_IDLE_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [AMP_WIDTH-1:0] sample_in,
   input  logic [1:0]           pd_mode,
   input  logic                 sample_valid,
   output logic                 sample_ready,
   output logic                 dac_cs_n,
   output logic                 dac_sclk,
   output logic                 dac_sdata,
   output logic                 busy,
   output logic                 frame_done
);

   // One down-counter times both the SCLK half-periods and the END phase.
   localparam int CNT_MAX = (SCLK_DIV > CS_IDLE_CYCLES) ? SCLK_DIV : CS_IDLE_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCLK_DIV - 1);
   localparam logic [CNT_W-1:0] END_LAST = CNT_W'(CS_IDLE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_SHIFT = 2'd2,
      ST_END   = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sclk_q, sclk_d;
   logic [3:0]       bit_cnt_q, bit_cnt_d;
   logic [15:0]      shift_q, shift_d;
   logic             frame_done_q, frame_done_d;
   logic             accept;
   logic [15:0]      in_word;

`ifdef DAC_SPI_TX_SKID_EN
   logic             buf_valid_q, buf_valid_d;
   logic [15:0]      buf_word_q, buf_word_d;
   logic             take_direct;
`endif

   // Left-justify the sample into the 12-bit data field and prepend the
   // two reserved zeros and the power-down bits.
   function automatic logic [15:0] pack_frame(input logic [AMP_WIDTH-1:0] smp,
                                              input logic [1:0]           pd);
      logic [11:0] data12;
      data12 = 12'(smp) << (12 - AMP_WIDTH);
      return {2'b00, pd, data12};
   endfunction

   assign in_word = pack_frame(sample_in, pd_mode);
   assign accept  = sample_valid && sample_ready;

   // State and datapath registers; reset abandons any frame in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         sclk_q       <= 1'b1;
         bit_cnt_q    <= 4'd0;
         shift_q      <= 16'd0;
         frame_done_q <= 1'b0;
`ifdef DAC_SPI_TX_SKID_EN
         buf_valid_q  <= 1'b0;
         buf_word_q   <= 16'd0;
`endif
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         sclk_q       <= sclk_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         frame_done_q <= frame_done_d;
`ifdef DAC_SPI_TX_SKID_EN
         buf_valid_q  <= buf_valid_d;
         buf_word_q   <= buf_word_d;
`endif
      end
   end

   // Next-state logic: frame sequencing, SCLK phase timing and shifting.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      sclk_d       = sclk_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      frame_done_d = 1'b0;
`ifdef DAC_SPI_TX_SKID_EN
      buf_valid_d  = buf_valid_q;
      buf_word_d   = buf_word_q;
      take_direct  = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_SETUP;
               cnt_d   = DIV_LAST;
               shift_d = in_word;
`ifdef DAC_SPI_TX_SKID_EN
               take_direct = 1'b1;
`endif
            end
         end

         ST_SETUP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               state_d   = ST_SHIFT;
               cnt_d     = DIV_LAST;
               sclk_d    = 1'b0;
               bit_cnt_d = 4'd15;
            end
         end

         ST_SHIFT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (!sclk_q) begin
               // End of a low phase: the DAC has taken the bit on the falling edge.
               if (bit_cnt_q == 4'd0) begin
                  // Last bit: leave the frame without a final rising edge inside cs_n.
                  state_d      = ST_END;
                  cnt_d        = END_LAST;
                  sclk_d       = 1'b1;
                  frame_done_d = 1'b1;
               end else begin
                  // Present the next bit together with the rising edge.
                  sclk_d    = 1'b1;
                  cnt_d     = DIV_LAST;
                  shift_d   = {shift_q[14:0], 1'b0};
                  bit_cnt_d = bit_cnt_q - 1'b1;
               end
            end else begin
               sclk_d = 1'b0;
               cnt_d  = DIV_LAST;
            end
         end

         ST_END: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
`ifdef DAC_SPI_TX_SKID_EN
               // Chain the next frame without an IDLE cycle when one is waiting.
               if (buf_valid_q) begin
                  state_d     = ST_SETUP;
                  cnt_d       = DIV_LAST;
                  shift_d     = buf_word_q;
                  buf_valid_d = 1'b0;
               end else if (accept) begin
                  state_d     = ST_SETUP;
                  cnt_d       = DIV_LAST;
                  shift_d     = in_word;
                  take_direct = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
`else
               state_d = ST_IDLE;
`endif
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

`ifdef DAC_SPI_TX_SKID_EN
      // Samples accepted mid-frame are parked until the current frame ends.
      if (accept && !take_direct) begin
         buf_valid_d = 1'b1;
         buf_word_d  = in_word;
      end
`endif
   end

   // Output decode from the registered state; pins idle high/high/low.
   always_comb begin
      dac_cs_n   = 1'b1;
      dac_sclk   = 1'b1;
      dac_sdata  = 1'b0;
      busy       = (state_q != ST_IDLE);
      frame_done = frame_done_q;
`ifdef DAC_SPI_TX_SKID_EN
      sample_ready = !buf_valid_q && !rst;
`else
      sample_ready = (state_q == ST_IDLE) && !rst;
`endif
      case (state_q)
         ST_SETUP: begin
            dac_cs_n  = 1'b0;
            dac_sdata = shift_q[15];
         end
         ST_SHIFT: begin
            dac_cs_n  = 1'b0;
            dac_sclk  = sclk_q;
            dac_sdata = shift_q[15];
         end
         default: begin
            dac_cs_n  = 1'b1;
         end
      endcase
   end

endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: randomized and directed stimulus for dac_spi_tx with a
// behavioural SPI receiver model (captures DIN on falling SCLK) and a queue
// of expected frame words built from accepted samples.
module tb_dac_spi_tx;

   localparam int AMPW = 12;
   localparam int DIV  = 2;
   localparam int CSI  = 2;
`ifdef DAC_SPI_TX_SKID_EN
   localparam int PERIOD = 32*DIV + CSI;
`else
   localparam int PERIOD = 32*DIV + CSI + 1;
`endif

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [AMPW-1:0] sample_in = '0;
   logic [1:0]      pd_mode = 2'b00;
   logic            sample_valid = 1'b0;
   logic            sample_ready, dac_cs_n, dac_sclk, dac_sdata, busy, frame_done;

   logic [11:0]     s1_sample = '0;
   logic [1:0]      s1_pd = 2'b00;
   logic            s1_valid = 1'b0;
   logic            s1_ready, cs1, sclk1, sd1, busy1, fd1;

   dac_spi_tx #(.AMP_WIDTH(AMPW), .SCLK_DIV(DIV), .CS_IDLE_CYCLES(CSI)) dut (
      .clk(clk), .rst(rst), .sample_in(sample_in), .pd_mode(pd_mode),
      .sample_valid(sample_valid), .sample_ready(sample_ready),
      .dac_cs_n(dac_cs_n), .dac_sclk(dac_sclk), .dac_sdata(dac_sdata),
      .busy(busy), .frame_done(frame_done));

   dac_spi_tx #(.AMP_WIDTH(12), .SCLK_DIV(1), .CS_IDLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .sample_in(s1_sample), .pd_mode(s1_pd),
      .sample_valid(s1_valid), .sample_ready(s1_ready),
      .dac_cs_n(cs1), .dac_sclk(sclk1), .dac_sdata(sd1),
      .busy(busy1), .frame_done(fd1));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: the word the DAC should receive for a given sample.
   function automatic logic [31:0] model_word(input logic [AMPW-1:0] s, input logic [1:0] p);
      logic [11:0] d;
      d = 12'(s) << (12 - AMPW);
      return {16'd0, 2'b00, p, d};
   endfunction

   // Receiver model state for the main DUT
   logic [31:0] exp_q[$];
   int          fall_t[$];
   logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_sd = 1'b0, prev_busy = 1'b0;
   logic        in_frame = 1'b0;
   logic [15:0] word = '0, last_word = '0;
   int          low_cnt = 0, falls = 0, frames = 0, fd_pulses = 0;
   int          t_rise = 0, sd_glitch = 0, idle_edges = 0;

   always @(negedge clk) begin
      logic [31:0] e;
      if (rst) begin
         exp_q.delete();
         in_frame  = 1'b0;
         prev_cs   = 1'b1;
         prev_sclk = 1'b1;
         prev_sd   = 1'b0;
         prev_busy = 1'b0;
      end else begin
         if (sample_valid && sample_ready) exp_q.push_back(model_word(sample_in, pd_mode));
         if (frame_done) fd_pulses++;
         if (prev_cs && dac_cs_n && dac_sclk != prev_sclk) idle_edges++;
         if (!dac_cs_n) begin
            if (prev_cs) begin
               in_frame = 1'b1;
               low_cnt  = 0;
               falls    = 0;
               word     = '0;
               fall_t.push_back(cyc);
            end
            low_cnt++;
            if (!prev_sclk && !dac_sclk && dac_sdata != prev_sd) sd_glitch++;
            if (prev_sclk && !dac_sclk) begin
               word = {word[14:0], dac_sdata};
               falls++;
            end
         end else if (!prev_cs && in_frame) begin
            in_frame  = 1'b0;
            frames++;
            t_rise    = cyc;
            last_word = word;
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            chk("frame_word", {16'd0, word}, e);
            chk("cs_low_len", low_cnt, 32*DIV);
            chk("sclk_falls", falls, 16);
            chk("frame_done_at_end", frame_done, 1);
         end
         if (prev_busy && !busy) chk("busy_tail", cyc - t_rise, CSI);
         prev_cs   = dac_cs_n;
         prev_sclk = dac_sclk;
         prev_sd   = dac_sdata;
         prev_busy = busy;
      end
   end

   // Receiver model for the fast-clock instance
   logic        p_cs1 = 1'b1, p_sclk1 = 1'b1;
   logic [15:0] w1 = '0;
   int          low1 = 0, tog1 = 0;

   always @(negedge clk) begin
      if (!cs1) begin
         if (p_cs1) begin
            low1 = 0;
            tog1 = 0;
            w1   = '0;
         end
         low1++;
         if (!p_cs1 && sclk1 != p_sclk1) tog1++;
         if (p_sclk1 && !sclk1) w1 = {w1[14:0], sd1};
      end
      p_cs1   = cs1;
      p_sclk1 = sclk1;
   end

   // Present one sample and hold it until the DUT takes it.
   task automatic send(input logic [AMPW-1:0] s, input logic [1:0] p);
      int n = 0;
      sample_in    = s;
      pd_mode      = p;
      sample_valid = 1'b1;
      @(negedge clk);
      while (!sample_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (!sample_ready) chk("ready_wait", sample_ready, 1);
      @(posedge clk);
      #1 sample_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((busy || exp_q.size() != 0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", busy, 0);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      int k;
      int f0;
      int guard;
      logic acc;

      // Reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_cs_n", dac_cs_n, 1);
      chk("rst_sclk", dac_sclk, 1);
      chk("rst_sdata", dac_sdata, 0);
      chk("rst_busy", busy, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_ready", sample_ready, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("ready_after_rst", sample_ready, 1);
      @(posedge clk);
      #1;

      // Single frames with fixed patterns
      send(12'h555, 2'b00);
      wait_idle();
      chk("t1_word", last_word, 16'h0555);
      send(12'hFFF, 2'b11);
      wait_idle();
      chk("t2_word_ones", last_word, 16'h3FFF);
      send(12'h000, 2'b00);
      wait_idle();
      chk("t2_word_zero", last_word, 16'h0000);

      // Continuous ramp with valid held high
      fall_t.delete();
      k = 0;
      guard = 0;
      sample_valid = 1'b1;
      while (k < 20 && guard < 3000) begin
         sample_in = AMPW'(12'h100 + k);
         pd_mode   = 2'(k);
         @(negedge clk);
         acc = sample_ready;
         @(posedge clk);
         #1;
         if (acc) k++;
         guard++;
      end
      sample_valid = 1'b0;
      chk("ramp_accepts", k, 20);
      wait_idle();
      chk("ramp_frames", fall_t.size(), 20);
      for (int i = 1; i < fall_t.size(); i++) chk("ramp_period", fall_t[i] - fall_t[i-1], PERIOD);

      // Sample offered mid-frame
      send(12'h123, 2'b01);
      repeat (9) @(posedge clk);
      #1;
      f0 = frames;
      sample_in    = 12'h456;
      pd_mode      = 2'b10;
      sample_valid = 1'b1;
      @(negedge clk);
`ifdef DAC_SPI_TX_SKID_EN
      chk("t4_ready_skid", sample_ready, 1);
      @(posedge clk);
      #1;
      sample_in = 12'h789;
      pd_mode   = 2'b00;
      @(negedge clk);
      chk("t4_third_stall", sample_ready, 0);
`else
      chk("t4_ready_hold", sample_ready, 0);
`endif
      n = 0;
      while (!sample_ready && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("t4_accept_after_frame", frames - f0, 1);
`ifdef DAC_SPI_TX_SKID_EN
      chk("t4_accept_busy", busy, 1);
`else
      chk("t4_accept_idle", busy, 0);
`endif
      @(posedge clk);
      #1 sample_valid = 1'b0;
      wait_idle();

      // Reset in the middle of a frame
      send(12'hABC, 2'b10);
      n = 0;
      @(negedge clk);
      #1;
      while (falls < 8 && n < 400) begin
         @(negedge clk);
         #1;
         n++;
      end
      chk("t5_reach_edge8", falls, 8);
      rst = 1'b1;
      @(negedge clk);
      #1;
      chk("t5_cs_n", dac_cs_n, 1);
      chk("t5_sclk", dac_sclk, 1);
      chk("t5_sdata", dac_sdata, 0);
      chk("t5_busy", busy, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("t5_ready", sample_ready, 1);
      @(posedge clk);
      #1;
      f0 = frames;
      send(12'h3C3, 2'b01);
      wait_idle();
      chk("t5_next_frame", frames - f0, 1);
      chk("t5_word", last_word, 16'h13C3);

      // Random samples with random gaps
      for (int r = 0; r < 15; r++) begin
         repeat ($urandom_range(0, 80)) @(posedge clk);
         #1;
         send(AMPW'($urandom), 2'($urandom));
      end
      wait_idle();

      // Fastest timing on the second instance
      s1_sample = 12'hA5A;
      s1_pd     = 2'b01;
      s1_valid  = 1'b1;
      n = 0;
      @(negedge clk);
      while (!s1_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1 s1_valid = 1'b0;
      n = 0;
      @(negedge clk);
      while (busy1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("t6_idle", busy1, 0);
      chk("t6_word", w1, 16'h1A5A);
      chk("t6_cs_low", low1, 32);
      chk("t6_toggles", tog1, 31);

      // Whole-run invariants
      chk("frame_done_count", fd_pulses, frames);
      chk("sdata_stable_low", sd_glitch, 0);
      chk("no_idle_sclk", idle_edges, 0);
      chk("exp_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule
